// File: rtl/shift_ring_counter_pkg.sv
// shift_ring_counter_pkg: mode/direction encodings and period helper for the ring counter
package shift_ring_counter_pkg;
  localparam logic MODE_RING = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  function automatic int period(logic mode, int width);
    return mode == MODE_JOHNSON ? 2 * width : width;
  endfunction
endpackage

// File: rtl/shift_ring_counter_if.sv
// shift_ring_counter_if: control inputs and pattern outputs of the ring counter
interface shift_ring_counter_if #(parameter int WIDTH = 4);
  logic en, load, mode, dir, wrap;
  logic [WIDTH-1:0] ori, count, seed;
  modport master(output en, load, ori, mode, dir, input count, wrap, seed);
  modport slave(input en, load, ori, mode, dir, output count, wrap, seed);
endinterface

// File: rtl/shift_period_tracker.sv
// shift_period_tracker: step counter, wrap pulse and mode-change restart detection
module shift_period_tracker
  import shift_ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic shift,
  input  logic load,
  input  logic mode,
  output logic wrap,
  output logic restart
);
  localparam int SW = $clog2(2 * WIDTH);
  logic [SW-1:0] step, last_step;
  logic last_mode;
  assign restart = !load && (mode != last_mode);
  assign last_step = SW'(period(mode, WIDTH) - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step <= '0;
      wrap <= 1'b0;
      last_mode <= MODE_RING;
    end else if (load) begin
      step <= '0;
      wrap <= 1'b0;
    end else if (restart) begin
      step <= '0;
      wrap <= 1'b0;
      last_mode <= mode;
    end else if (shift) begin
      step <= step == last_step ? '0 : step + SW'(1);
      wrap <= step == last_step;
    end else begin
      wrap <= 1'b0;
    end
  end
endmodule

// File: rtl/shift_ring_counter.sv
// shift_ring_counter: loadable ring/Johnson pattern generator with direction, enable and wrap pulse
module shift_ring_counter
  import shift_ring_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input logic clk,
  input logic rst,
  shift_ring_counter_if.slave bus
);
  logic [WIDTH-1:0] count, seed, nxt;
  logic restart, wrap;
  always_comb
    nxt = bus.mode == MODE_RING
        ? (bus.dir == DIR_LEFT ? {count[WIDTH-2:0], count[WIDTH-1]} : {count[0], count[WIDTH-1:1]})
        : (bus.dir == DIR_LEFT ? {count[WIDTH-2:0], ~count[WIDTH-1]} : {~count[0], count[WIDTH-1:1]});
  // a mode change restarts the period from the current pattern and holds count for that edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= RESET_VAL;
      seed <= RESET_VAL;
    end else if (bus.load) begin
      count <= bus.ori;
      seed <= bus.ori;
    end else if (restart) begin
      seed <= count;
    end else if (bus.en) begin
      count <= nxt;
    end
  end
  shift_period_tracker #(.WIDTH(WIDTH)) u_tracker (
    .clk(clk),
    .rst(rst),
    .shift(bus.en),
    .load(bus.load),
    .mode(bus.mode),
    .wrap(wrap),
    .restart(restart)
  );
  assign bus.count = count;
  assign bus.seed = seed;
  assign bus.wrap = wrap;
endmodule

// File: tb/tb_shift_ring_counter.sv
// tb_shift_ring_counter: directed test-plan sequences plus randomized run against a behavioural model
module tb_shift_ring_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  shift_ring_counter_if #(.WIDTH(4)) bus ();
  shift_ring_counter_if #(.WIDTH(2)) bus2 ();
  shift_ring_counter #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  shift_ring_counter #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  always #5 clk = ~clk;
  logic [3:0] m_cnt, m_seed;
  int m_step;
  logic m_wrap, m_last;
  function automatic logic [3:0] shift_pat(logic [3:0] c, logic md, logic dr);
    int v, msb, lsb;
    v = int'(c);
    msb = (v >> 3) & 1;
    lsb = v & 1;
    if (!dr) v = ((v << 1) & 15) | (md ? 1 - msb : msb);
    else v = (v >> 1) | ((md ? 1 - lsb : lsb) << 3);
    return 4'(v);
  endfunction
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt <= 4'd1;
      m_seed <= 4'd1;
      m_step <= 0;
      m_wrap <= 1'b0;
      m_last <= 1'b0;
    end else if (bus.load) begin
      m_cnt <= bus.ori;
      m_seed <= bus.ori;
      m_step <= 0;
      m_wrap <= 1'b0;
    end else if (bus.mode != m_last) begin
      m_seed <= m_cnt;
      m_step <= 0;
      m_wrap <= 1'b0;
      m_last <= bus.mode;
    end else if (bus.en) begin
      m_cnt <= shift_pat(m_cnt, bus.mode, bus.dir);
      m_step <= (m_step + 1) % (bus.mode ? 8 : 4);
      m_wrap <= (m_step + 1) == (bus.mode ? 8 : 4);
    end else begin
      m_wrap <= 1'b0;
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic test_reset();
    tick();
    checks++;
    if (bus.count !== 4'b0001 || bus.wrap !== 1'b0 || bus.seed !== 4'b0001) begin
      errors++;
      $display("FAIL reset count=%b wrap=%b seed=%b want 0001/0/0001", bus.count, bus.wrap, bus.seed);
    end
    checks++;
    if (bus2.count !== 2'b01 || bus2.wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_w2 count=%b wrap=%b want 01/0", bus2.count, bus2.wrap);
    end
    rst = 1'b1;
  endtask
  task automatic test_ring_left();
    logic [3:0] exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.mode = 1'b0;
    bus.dir = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.count !== exp[i] || bus.wrap !== (i == 3)) begin
        errors++;
        $display("FAIL ring_left[%0d] count=%b wrap=%b want %b/%0d", i, bus.count, bus.wrap, exp[i], i == 3);
      end
    end
    bus.en = 1'b0;
  endtask
  task automatic test_ring_right();
    logic [3:0] exp [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    bus.load = 1'b1;
    bus.ori = 4'b1000;
    tick();
    bus.load = 1'b0;
    checks++;
    if (bus.count !== 4'b1000 || bus.wrap !== 1'b0 || bus.seed !== 4'b1000) begin
      errors++;
      $display("FAIL ring_right_load count=%b wrap=%b seed=%b want 1000/0/1000", bus.count, bus.wrap, bus.seed);
    end
    bus.dir = 1'b1;
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.count !== exp[i] || bus.wrap !== (i == 3)) begin
        errors++;
        $display("FAIL ring_right[%0d] count=%b wrap=%b want %b/%0d", i, bus.count, bus.wrap, exp[i], i == 3);
      end
    end
    bus.en = 1'b0;
  endtask
  task automatic test_johnson();
    logic [3:0] exp [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    bus.load = 1'b1;
    bus.ori = 4'b0000;
    tick();
    bus.load = 1'b0;
    bus.mode = 1'b1;
    tick();
    checks++;
    if (bus.count !== 4'b0000 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL johnson_restart count=%b wrap=%b want 0000/0", bus.count, bus.wrap);
    end
    bus.dir = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.count !== exp[i] || bus.wrap !== (i == 7)) begin
        errors++;
        $display("FAIL johnson[%0d] count=%b wrap=%b want %b/%0d", i, bus.count, bus.wrap, exp[i], i == 7);
      end
    end
    bus.en = 1'b0;
  endtask
  task automatic test_mode_change();
    logic [3:0] exp [8] = '{4'b1001, 4'b0010, 4'b0101, 4'b1011, 4'b0110, 4'b1101, 4'b1010, 4'b0100};
    bus.load = 1'b1;
    bus.ori = 4'b0001;
    tick();
    bus.load = 1'b0;
    bus.mode = 1'b0;
    tick();
    bus.en = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.count !== 4'b0100 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL mode_pre count=%b wrap=%b want 0100/0", bus.count, bus.wrap);
    end
    bus.mode = 1'b1;
    tick();
    checks++;
    if (bus.count !== 4'b0100 || bus.wrap !== 1'b0 || bus.seed !== 4'b0100) begin
      errors++;
      $display("FAIL mode_hold count=%b wrap=%b seed=%b want 0100/0/0100", bus.count, bus.wrap, bus.seed);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.count !== exp[i] || bus.wrap !== (i == 7)) begin
        errors++;
        $display("FAIL mode_johnson[%0d] count=%b wrap=%b want %b/%0d", i, bus.count, bus.wrap, exp[i], i == 7);
      end
    end
    bus.en = 1'b0;
  endtask
  task automatic test_load_en_hold();
    bus.load = 1'b1;
    bus.en = 1'b1;
    bus.ori = 4'b1010;
    tick();
    bus.load = 1'b0;
    bus.en = 1'b0;
    checks++;
    if (bus.count !== 4'b1010 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_en count=%b wrap=%b want 1010/0", bus.count, bus.wrap);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.count !== 4'b1010 || bus.wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] count=%b wrap=%b want 1010/0", i, bus.count, bus.wrap);
      end
    end
  endtask
  task automatic test_async_reset();
    bus.mode = 1'b0;
    tick();
    bus.en = 1'b1;
    tick();
    checks++;
    if (bus.count !== 4'b0101) begin
      errors++;
      $display("FAIL pre_reset count=%b want 0101", bus.count);
    end
    tick();
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.count !== 4'b0001 || bus.wrap !== 1'b0 || bus.seed !== 4'b0001) begin
      errors++;
      $display("FAIL async_reset count=%b wrap=%b seed=%b want 0001/0/0001", bus.count, bus.wrap, bus.seed);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.count !== 4'b0010 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL after_reset count=%b wrap=%b want 0010/0", bus.count, bus.wrap);
    end
    bus.en = 1'b0;
  endtask
  task automatic test_width2();
    bus2.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus2.count !== (i % 2 == 0 ? 2'b10 : 2'b01) || bus2.wrap !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL width2[%0d] count=%b wrap=%b want %b/%0d", i, bus2.count, bus2.wrap,
                 i % 2 == 0 ? 2'b10 : 2'b01, i % 2 == 1);
      end
    end
    bus2.en = 1'b0;
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.load = $urandom_range(15) == 0;
      bus.ori = 4'($urandom);
      bus.mode = $urandom_range(11) == 0 ? ~bus.mode : bus.mode;
      bus.dir = $urandom_range(9) == 0 ? ~bus.dir : bus.dir;
      bus.en = $urandom_range(3) != 0;
      tick();
      checks++;
      if (bus.count !== m_cnt || bus.wrap !== m_wrap || bus.seed !== m_seed) begin
        errors++;
        $display("FAIL random[%0d] count=%b wrap=%b seed=%b want %b/%b/%b", i, bus.count, bus.wrap,
                 bus.seed, m_cnt, m_wrap, m_seed);
      end
    end
    bus.en = 1'b0;
    bus.load = 1'b0;
  endtask
  initial begin
    bus.en = 1'b0;
    bus.load = 1'b0;
    bus.mode = 1'b0;
    bus.dir = 1'b0;
    bus.ori = '0;
    bus2.en = 1'b0;
    bus2.load = 1'b0;
    bus2.mode = 1'b0;
    bus2.dir = 1'b0;
    bus2.ori = '0;
    test_reset();
    test_ring_left();
    test_ring_right();
    test_johnson();
    test_mode_change();
    test_load_en_hold();
    test_async_reset();
    test_width2();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
